j68_addsub_iter: RTL and testbench
==================================

J68_ADDSUB_ITER -- requirements
Module: j68_addsub_iter

Interface
REQ-001 SHALL have parameter DATA_W, default 32: operand/result width; a multiple of 32.
REQ-002 SHALL have parameter SLICE_W, default 8: bits processed per clock; one of 1, 2, 4, 8.
REQ-003 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  in  1  reset; synchronous and active-high.
REQ-005 SHALL have port start  in  1  request; accepted only when ready=1.
REQ-006 SHALL have port ready  out  1  high when a start can be accepted.
REQ-007 SHALL have port add_sub  in  1  operation select: 1 = add, 0 = subtract (dataa - datab).
REQ-008 SHALL have port ext  in  1  extend mode (ADDX/SUBX): include x_in; sticky Z.
REQ-009 SHALL have port size  in  2  operand size: 00 = 8, 01 = 16, 10 = 32, 11 = DATA_W bits.
REQ-010 SHALL have ports dataa, datab  in  DATA_W  operands (dataa is the destination).
REQ-011 SHALL have ports x_in, z_in  in  1  incoming X and Z flags.
REQ-012 SHALL have port done  out  1  one-cycle pulse; result and flags valid.
REQ-013 SHALL have port result  out  DATA_W  sum or difference.
REQ-014 SHALL have ports x_out, n_out, z_out, v_out, c_out  out  1 each  68000 CCR flags.

Function
REQ-015 SHALL implement FSM IDLE -> CALC -> DONE; ready = (state != CALC).
REQ-016 SHALL, on an edge with start=1 and ready=1, register add_sub, ext, size, dataa, datab, x_in and z_in, clear the slice counter, and enter CALC.
REQ-017 SHALL ignore start while in CALC; the captured inputs SHALL be unaffected.
REQ-018 SHALL use slice count N = sizebits/SLICE_W and process one slice per CALC edge, LSB slice first.
REQ-019 SHALL seed the slice-0 carry/borrow with (ext ? x_in : 0) and propagate it between slices in a registered carry.
REQ-020 SHALL, after the Nth CALC edge, enter DONE; done = (state == DONE), so done is high in the cycle after the Nth edge following acceptance.
REQ-021 SHALL go DONE -> IDLE on the next edge, or DONE -> CALC if start=1 in DONE (back-to-back operation).
REQ-022 SHALL compute add as dataa + datab + cin and subtract as dataa - datab - cin, modulo 2^sizebits.
REQ-023 SHALL pass result bits above sizebits through unchanged from the captured dataa.
REQ-024 SHALL set c_out to carry-out (add) or borrow (subtract) from bit sizebits-1, and SHALL set x_out = c_out.
REQ-025 SHALL set n_out to result[sizebits-1].
REQ-026 SHALL set v_out to two's-complement signed overflow at the operand size.
REQ-027 SHALL set z_out to (sized result == 0) when ext=0, and to z_in & (sized result == 0) when ext=1.
REQ-028 SHALL hold result and flags stable from DONE until the next accepted start; they SHALL update only during CALC.

Reset
REQ-029 SHALL, while rst=1 on any edge, regardless of state, force IDLE with ready=1, done=0, result=0, all flags=0, and counter/carry=0.
REQ-030 SHALL treat rst=1 together with start=1 as reset, not accepting the start.
REQ-031 SHALL abandon an operation reset mid-CALC; no done pulse SHALL follow.

Verification (DATA_W=32, SLICE_W=8 unless stated)
REQ-032 SHALL cover: add, size=10, dataa 0x7FFFFFFF, datab 0x00000001 -> result 0x80000000, N=1, V=1, Z=0, C=X=0, done 4 edges after acceptance.
REQ-033 SHALL cover: sub, size=00, dataa 0x12345600, datab 0x00000001 -> result 0x123456FF, N=1, C=X=1, V=0, Z=0, done after 1 edge.
REQ-034 SHALL cover: add, ext=1, size=01, x_in=1, dataa 0x0000FFFF, datab 0 -> result 0x00000000, C=X=1; Z=1 when z_in=1, Z=0 when z_in=0.
REQ-035 SHALL cover: start pulsed mid-CALC with different operands -> ignored, original result produced; a second start in the DONE cycle -> accepted, done 4 edges later.
REQ-036 SHALL cover: rst asserted on the 2nd CALC edge -> IDLE, ready=1, outputs 0, no done pulse.
REQ-037 SHALL cover: SLICE_W=1 and DATA_W=64 with size=11, random operands versus reference arithmetic -> results and flags match, done after 64 edges.

Source files
------------

// File: rtl/j68_addsub_iter.sv
// Iterative 68000-style ADD/SUB/ADDX/SUBX unit.
// Processes SLICE_W bits per clock, LSB slice first, with a registered
// carry/borrow between slices. Produces 68000 CCR flags at the operand size.
module j68_addsub_iter #(
    parameter int DATA_W  = 32,
    parameter int SLICE_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              ready,
    input  logic              add_sub,
    input  logic              ext,
    input  logic [1:0]        size,
    input  logic [DATA_W-1:0] dataa,
    input  logic [DATA_W-1:0] datab,
    input  logic              x_in,
    input  logic              z_in,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              x_out,
    output logic              n_out,
    output logic              z_out,
    output logic              v_out,
    output logic              c_out
);

    localparam int NS = DATA_W / SLICE_W;
    localparam int IW = $clog2(NS);
    localparam int CW = IW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_reg;
    logic                ready_reg;
    logic                done_reg;
    logic                add_reg;
    logic                ext_reg;
    logic [1:0]          size_reg;
    logic [DATA_W-1:0]   a_reg;
    logic [DATA_W-1:0]   b_reg;
    logic                z_in_reg;
    logic [CW-1:0]       cnt_reg;
    logic                carry_reg;
    logic                zacc_reg;
    logic [DATA_W-1:0]   result_reg;
    logic                c_flag_reg;
    logic                n_flag_reg;
    logic                z_flag_reg;
    logic                v_flag_reg;

    logic [SLICE_W-1:0]  a_sl [NS];
    logic [SLICE_W-1:0]  b_sl [NS];
    logic [IW-1:0]       idx;
    logic [SLICE_W-1:0]  a_cur;
    logic [SLICE_W-1:0]  b_cur;
    logic [SLICE_W:0]    add_w;
    logic [SLICE_W:0]    sub_w;
    logic [SLICE_W-1:0]  slice_sum;
    logic                slice_cout;
    logic                slice_zero;
    logic                v_next;
    logic                z_next;
    logic [CW-1:0]       last_cnt;
    logic                last_slice;
    logic [DATA_W-1:0]   result_next;

    assign idx = cnt_reg[IW-1:0];

    // Slice views of the captured operands and the merged next result.
    // On the first slice the untouched upper bits are reloaded from dataa,
    // so bits above the operand size pass through unchanged.
    genvar gi;
    generate
        for (gi = 0; gi < NS; gi++) begin : g_slice
            assign a_sl[gi] = a_reg[gi*SLICE_W +: SLICE_W];
            assign b_sl[gi] = b_reg[gi*SLICE_W +: SLICE_W];
            assign result_next[gi*SLICE_W +: SLICE_W] =
                (cnt_reg == CW'(gi)) ? slice_sum :
                ((cnt_reg == '0) ? a_sl[gi] : result_reg[gi*SLICE_W +: SLICE_W]);
        end
    endgenerate

    // Index of the final slice for the captured operand size.
    always_comb begin
        case (size_reg)
            2'b00:   last_cnt = CW'(8 / SLICE_W - 1);
            2'b01:   last_cnt = CW'(16 / SLICE_W - 1);
            2'b10:   last_cnt = CW'(32 / SLICE_W - 1);
            default: last_cnt = CW'(NS - 1);
        endcase
    end

    assign last_slice = (cnt_reg == last_cnt);

    // One slice of add/subtract plus the flag terms evaluated on the top slice.
    always_comb begin
        a_cur = a_sl[idx];
        b_cur = b_sl[idx];
        add_w = {1'b0, a_cur} + {1'b0, b_cur} + {{SLICE_W{1'b0}}, carry_reg};
        sub_w = {1'b0, a_cur} - {1'b0, b_cur} - {{SLICE_W{1'b0}}, carry_reg};
        if (add_reg) begin
            slice_sum  = add_w[SLICE_W-1:0];
            slice_cout = add_w[SLICE_W];
            v_next     = (a_cur[SLICE_W-1] == b_cur[SLICE_W-1]) &&
                         (slice_sum[SLICE_W-1] != a_cur[SLICE_W-1]);
        end else begin
            slice_sum  = sub_w[SLICE_W-1:0];
            slice_cout = sub_w[SLICE_W];
            v_next     = (a_cur[SLICE_W-1] != b_cur[SLICE_W-1]) &&
                         (slice_sum[SLICE_W-1] != a_cur[SLICE_W-1]);
        end
        slice_zero = (slice_sum == '0);
        z_next     = zacc_reg & slice_zero & (~ext_reg | z_in_reg);
    end

    // Control FSM, operand capture, slice datapath state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            ready_reg  <= 1'b1;
            done_reg   <= 1'b0;
            add_reg    <= 1'b0;
            ext_reg    <= 1'b0;
            size_reg   <= 2'b00;
            a_reg      <= '0;
            b_reg      <= '0;
            z_in_reg   <= 1'b0;
            cnt_reg    <= '0;
            carry_reg  <= 1'b0;
            zacc_reg   <= 1'b0;
            result_reg <= '0;
            c_flag_reg <= 1'b0;
            n_flag_reg <= 1'b0;
            z_flag_reg <= 1'b0;
            v_flag_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_CALC: begin
                    result_reg <= result_next;
                    carry_reg  <= slice_cout;
                    zacc_reg   <= zacc_reg & slice_zero;
                    cnt_reg    <= cnt_reg + 1'b1;
                    if (last_slice) begin
                        c_flag_reg <= slice_cout;
                        n_flag_reg <= slice_sum[SLICE_W-1];
                        z_flag_reg <= z_next;
                        v_flag_reg <= v_next;
                        state_reg  <= S_DONE;
                        ready_reg  <= 1'b1;
                        done_reg   <= 1'b1;
                    end
                end
                S_IDLE, S_DONE: begin
                    if (start) begin
                        add_reg   <= add_sub;
                        ext_reg   <= ext;
                        size_reg  <= size;
                        a_reg     <= dataa;
                        b_reg     <= datab;
                        z_in_reg  <= z_in;
                        cnt_reg   <= '0;
                        carry_reg <= ext & x_in;
                        zacc_reg  <= 1'b1;
                        state_reg <= S_CALC;
                        ready_reg <= 1'b0;
                        done_reg  <= 1'b0;
                    end else begin
                        state_reg <= S_IDLE;
                        ready_reg <= 1'b1;
                        done_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    ready_reg <= 1'b1;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign ready  = ready_reg;
    assign done   = done_reg;
    assign result = result_reg;
    assign x_out  = c_flag_reg;
    assign c_out  = c_flag_reg;
    assign n_out  = n_flag_reg;
    assign z_out  = z_flag_reg;
    assign v_out  = v_flag_reg;

endmodule

// File: tb/tb_j68_addsub_iter.sv
// Scoreboard bench for j68_addsub_iter: a 32-bit/8-bit-slice instance and a
// 64-bit/1-bit-slice instance, checked against a plain-arithmetic model.
module tb_j68_addsub_iter;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  flg;   // {x, n, z, v, c}
        int          due;
        int          id;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic        start_s [2];
    logic        add_s   [2];
    logic        ext_s   [2];
    logic        x_s     [2];
    logic        z_s     [2];
    logic [1:0]  size_s  [2];
    logic [63:0] a_s     [2];
    logic [63:0] b_s     [2];

    wire  [31:0] res0;
    wire  [63:0] res1;
    wire         rdy0, rdy1, dn0, dn1;
    wire  [4:0]  fl0, fl1;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   op_id = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    j68_addsub_iter dut0 (
        .clk(clk), .rst(rst), .start(start_s[0]), .ready(rdy0),
        .add_sub(add_s[0]), .ext(ext_s[0]), .size(size_s[0]),
        .dataa(a_s[0][31:0]), .datab(b_s[0][31:0]),
        .x_in(x_s[0]), .z_in(z_s[0]), .done(dn0), .result(res0),
        .x_out(fl0[4]), .n_out(fl0[3]), .z_out(fl0[2]), .v_out(fl0[1]), .c_out(fl0[0])
    );

    j68_addsub_iter #(.DATA_W(64), .SLICE_W(1)) dut1 (
        .clk(clk), .rst(rst), .start(start_s[1]), .ready(rdy1),
        .add_sub(add_s[1]), .ext(ext_s[1]), .size(size_s[1]),
        .dataa(a_s[1]), .datab(b_s[1]),
        .x_in(x_s[1]), .z_in(z_s[1]), .done(dn1), .result(res1),
        .x_out(fl1[4]), .n_out(fl1[3]), .z_out(fl1[2]), .v_out(fl1[1]), .c_out(fl1[0])
    );

    function automatic logic [63:0] res_of(input int d);
        return (d == 0) ? {32'b0, res0} : res1;
    endfunction
    function automatic logic [4:0] flg_of(input int d);
        return (d == 0) ? fl0 : fl1;
    endfunction
    function automatic logic done_of(input int d);
        return (d == 0) ? dn0 : dn1;
    endfunction
    function automatic logic ready_of(input int d);
        return (d == 0) ? rdy0 : rdy1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: sized two's-complement arithmetic done with wide integers.
    function automatic void ref_op(input bit add, input bit ext, input int bits, input int dw,
                                   input logic [63:0] a, input logic [63:0] b,
                                   input bit x, input bit z,
                                   output logic [63:0] r, output logic [4:0] f);
        logic [65:0] mask, as, bs, sum, cin;
        logic signed [67:0] sa, sb, tv, lo, hi;
        bit c, n, v, zz;
        mask = (66'd1 << bits) - 66'd1;
        as   = {2'b00, a} & mask;
        bs   = {2'b00, b} & mask;
        cin  = (ext && x) ? 66'd1 : 66'd0;
        if (add) begin
            sum = as + bs + cin;
            c   = (sum > mask);
        end else begin
            c   = (as < bs + cin);
            sum = as - bs - cin;
        end
        sum = sum & mask;
        sa = signed'({2'b00, as});
        sb = signed'({2'b00, bs});
        if (as[bits-1]) sa = sa - (68'sd1 <<< bits);
        if (bs[bits-1]) sb = sb - (68'sd1 <<< bits);
        tv = add ? (sa + sb + signed'({2'b00, cin})) : (sa - sb - signed'({2'b00, cin}));
        lo = -(68'sd1 <<< (bits - 1));
        hi = (68'sd1 <<< (bits - 1)) - 68'sd1;
        v  = (tv < lo) || (tv > hi);
        n  = sum[bits-1];
        zz = (sum == 66'd0) && (!ext || z);
        r  = (a & ~mask[63:0]) | sum[63:0];
        if (dw == 32) r[63:32] = 32'b0;
        f  = {c, n, zz, v, c};
    endfunction

    // Drive one request; caller is just after an edge with ready known high.
    task automatic issue(input int d, input bit add, input bit ext, input logic [1:0] sz,
                         input logic [63:0] a, input logic [63:0] b, input bit x, input bit z,
                         input bit push, output logic [63:0] er);
        int bits, dw, sw;
        exp_t e;
        dw   = (d == 0) ? 32 : 64;
        sw   = (d == 0) ? 8 : 1;
        bits = (sz == 2'b00) ? 8 : (sz == 2'b01) ? 16 : (sz == 2'b10) ? 32 : dw;
        add_s[d] = add; ext_s[d] = ext; size_s[d] = sz;
        a_s[d] = a; b_s[d] = b; x_s[d] = x; z_s[d] = z;
        start_s[d] = 1'b1;
        @(posedge clk); #1;
        start_s[d] = 1'b0;
        ref_op(add, ext, bits, dw, a, b, x, z, e.res, e.flg);
        e.due = cyc + bits / sw;
        e.id  = op_id++;
        er    = e.res;
        if (push) begin
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    task automatic wait_done(input int d, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done_of(d) === 1'b1) return;
            @(posedge clk); #1;
        end
        n_checks++;
        $display("FAIL wait_done dut%0d: done not seen within %0d cycles", d, budget);
    endtask

    // Monitor: pop and compare on every done pulse.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (done_of(d) === 1'b1) begin
                exp_t e;
                if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                    chk($sformatf("dut%0d_spurious_done", d), 64'd1, 64'd0);
                end else begin
                    e = (d == 0) ? q0.pop_front() : q1.pop_front();
                    chk($sformatf("dut%0d_op%0d_result", d, e.id), res_of(d), e.res);
                    chk($sformatf("dut%0d_op%0d_flags", d, e.id), {59'b0, flg_of(d)}, {59'b0, e.flg});
                    chk($sformatf("dut%0d_op%0d_latency", d, e.id), 64'(cyc), 64'(e.due));
                    $display("dut%0d op%0d result=%h xnzvc=%b cycle=%0d", d, e.id, res_of(d), flg_of(d), cyc);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] er, er_a, ra, rb;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            start_s[d] = 0; add_s[d] = 0; ext_s[d] = 0; x_s[d] = 0; z_s[d] = 0;
            size_s[d] = 2'b00; a_s[d] = '0; b_s[d] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset_ready%0d", d), {63'b0, ready_of(d)}, 64'd1);
            chk($sformatf("reset_done%0d", d), {63'b0, done_of(d)}, 64'd0);
            chk($sformatf("reset_result%0d", d), res_of(d), 64'd0);
            chk($sformatf("reset_flags%0d", d), {59'b0, flg_of(d)}, 64'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // Signed overflow at 32 bits.
        issue(0, 1, 0, 2'b10, 64'h7FFFFFFF, 64'h1, 0, 0, 1, er);
        chk("busy_ready_low", {63'b0, rdy0}, 64'd0);
        wait_done(0, 10);
        chk("directed_add32_result", {32'b0, res0}, 64'h80000000);
        chk("directed_add32_flags", {59'b0, fl0}, {59'b0, 5'b01010});
        @(posedge clk); #1;

        // Byte subtract with borrow; upper bits pass through.
        issue(0, 0, 0, 2'b00, 64'h12345600, 64'h1, 0, 0, 1, er);
        wait_done(0, 10);
        chk("directed_sub8_result", {32'b0, res0}, 64'h123456FF);
        chk("directed_sub8_flags", {59'b0, fl0}, {59'b0, 5'b11001});
        repeat (3) begin @(posedge clk); #1; end
        chk("hold_result", {32'b0, res0}, er);

        // ADDX word with sticky Z, both z_in values.
        issue(0, 1, 1, 2'b01, 64'h0000FFFF, 64'h0, 1, 1, 1, er);
        wait_done(0, 10);
        chk("addx_z1_flags", {59'b0, fl0}, {59'b0, 5'b10101});
        issue(0, 1, 1, 2'b01, 64'h0000FFFF, 64'h0, 1, 0, 1, er);
        wait_done(0, 10);
        chk("addx_z0_flags", {59'b0, fl0}, {59'b0, 5'b10001});
        @(posedge clk); #1;

        // Start while busy is ignored; start in the done cycle is accepted.
        ra = {32'b0, $urandom}; rb = {32'b0, $urandom};
        issue(0, 1, 0, 2'b10, ra, rb, 0, 0, 1, er_a);
        @(posedge clk); #1;
        a_s[0] = ~ra; b_s[0] = 64'h5A5A5A5A; add_s[0] = 0; start_s[0] = 1'b1;
        chk("busy_ignores_start_ready", {63'b0, rdy0}, 64'd0);
        @(posedge clk); #1;
        start_s[0] = 1'b0;
        wait_done(0, 10);
        chk("busy_ignores_start_result", {32'b0, res0}, er_a);
        issue(0, 0, 0, 2'b10, {32'b0, $urandom}, {32'b0, $urandom}, 0, 0, 1, er);
        wait_done(0, 10);
        @(posedge clk); #1;

        // Reset on the second CALC edge abandons the operation.
        issue(0, 1, 0, 2'b10, 64'h11111111, 64'h22222222, 0, 0, 0, er);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midcalc_rst_ready", {63'b0, rdy0}, 64'd1);
        chk("midcalc_rst_done", {63'b0, dn0}, 64'd0);
        chk("midcalc_rst_result", {32'b0, res0}, 64'd0);
        chk("midcalc_rst_flags", {59'b0, fl0}, 64'd0);
        start_s[0] = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start_s[0] = 1'b0;
        chk("rst_with_start_ready", {63'b0, rdy0}, 64'd1);
        repeat (10) begin @(posedge clk); #1; end

        // Random back-to-back traffic on the 32-bit instance.
        for (int i = 0; i < 30; i++) begin
            issue(0, 1'($urandom), 1'($urandom), 2'($urandom),
                  {32'b0, $urandom}, {32'b0, $urandom}, 1'($urandom), 1'($urandom), 1, er);
            wait_done(0, 10);
        end
        @(posedge clk); #1;

        // Random traffic on the 64-bit, 1-bit-slice instance.
        for (int i = 0; i < 16; i++) begin
            logic [1:0] sz;
            sz = (i < 12) ? 2'b11 : 2'($urandom);
            issue(1, 1'($urandom), 1'($urandom), sz,
                  {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom), 1, er);
            wait_done(1, 80);
        end

        repeat (5) begin @(posedge clk); #1; end
        chk("queue0_drained", 64'(q0.size()), 64'd0);
        chk("queue1_drained", 64'(q1.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
